// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversion helpers.
// Helpers work on 32-bit zero-extended values, so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int ADDR_LEN_DEF    = 5;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int AE_THRESH_DEF   = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; unused upper bits are zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the i_clk domain.
// Plain flop chain: no logic between stages.
module ptr_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] r_q;
    if (gi == 0) begin : g_first
      always_ff @(posedge i_clk) begin
        if (i_srst) r_q <= '0;
        else        r_q <= i_d;
      end
    end else begin : g_next
      always_ff @(posedge i_clk) begin
        if (i_srst) r_q <= '0;
        else        r_q <= g_stage[gi-1].r_q;
      end
    end
  end

  assign o_q = g_stage[STAGES-1].r_q;

endmodule

// File: rtl/rd_ptr_handler.sv
// Read-domain pointer manager of the async FIFO: read pointer, RAM read address,
// synchronised write pointer, empty / almost-empty / level and sticky underflow.
module rd_ptr_handler
  import fifo_pkg::*;
#(
  parameter int ADDR_LEN    = ADDR_LEN_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = AE_THRESH_DEF
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_en,
  input  logic                rd_underflow_clr,
  input  logic [ADDR_LEN:0]   wr_ptr,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic [ADDR_LEN:0]   rd_ptr,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic [ADDR_LEN:0]   rd_level,
  output logic                rd_underflow
);

  localparam int PW = ADDR_LEN + 1;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_level;
  logic          r_empty;
  logic          r_almost_empty;
  logic          r_underflow;

  logic [PW-1:0] w_wq_ptr;
  logic [PW-1:0] w_wq_bin;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_level_next;
  logic          w_rd_inc;
  logic          w_underflow_set;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .i_clk  (rd_clk),
    .i_srst (rd_rst),
    .i_d    (wr_ptr),
    .o_q    (w_wq_ptr)
  );

  assign w_rd_inc        = rd_en & ~r_empty;
  assign w_underflow_set = rd_en & r_empty;
  assign w_bin_next      = r_bin + PW'(w_rd_inc);
  assign w_gray_next     = PW'(bin2gray(32'(w_bin_next)));
  assign w_wq_bin        = PW'(gray2bin(32'(w_wq_ptr)));
  // Wrap subtraction on the extended pointers: a full FIFO yields exactly 2**ADDR_LEN.
  assign w_level_next    = w_wq_bin - w_bin_next;

  // Flags are computed from the next pointer so a final read and a newly
  // synchronised write landing together never leave a stale empty.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= w_bin_next;
      r_ptr          <= w_gray_next;
      r_level        <= w_level_next;
      r_empty        <= (w_gray_next == w_wq_ptr);
      r_almost_empty <= (w_level_next <= PW'(AE_THRESH));
      if (w_underflow_set)       r_underflow <= 1'b1;
      else if (rd_underflow_clr) r_underflow <= 1'b0;
    end
  end

  assign rd_addr         = r_bin[ADDR_LEN-1:0];
  assign rd_ptr          = r_ptr;
  assign rd_empty        = r_empty;
  assign rd_almost_empty = r_almost_empty;
  assign rd_level        = r_level;
  assign rd_underflow    = r_underflow;

endmodule

// File: tb/tb_rd_ptr_handler.sv
// Directed and randomised bench for rd_ptr_handler, checked against a count-based reference model.
module tb_rd_ptr_handler;

  localparam int AL = 5;
  localparam int SS = 2;
  localparam int AE = 4;
  localparam int DEPTH = 1 << AL;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          rd_underflow_clr = 1'b0;
  logic [AL:0]   wr_ptr = '0;
  logic [AL-1:0] rd_addr;
  logic [AL:0]   rd_ptr;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AL:0]   rd_level;
  logic          rd_underflow;

  rd_ptr_handler #(.ADDR_LEN(AL), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .rd_clk           (rd_clk),
    .rd_rst           (rd_rst),
    .rd_en            (rd_en),
    .rd_underflow_clr (rd_underflow_clr),
    .wr_ptr           (wr_ptr),
    .rd_addr          (rd_addr),
    .rd_ptr           (rd_ptr),
    .rd_empty         (rd_empty),
    .rd_almost_empty  (rd_almost_empty),
    .rd_level         (rd_level),
    .rd_underflow     (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model in plain counts: total writes issued, total reads accepted,
  // and the write count the read side can see after the synchroniser delay.
  int wcnt = 0;
  int rcnt = 0;
  int hist [SS];
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_ae    = 1'b1;
  bit m_uf    = 1'b0;
  int prev_msb = 0;
  int msb_toggles = 0;

  function automatic logic [AL:0] gray_of(input int n);
    logic [AL:0] b;
    b = AL'(0);
    b = (AL+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d (wcnt=%0d rcnt=%0d)", tag, obs, exp_v, wcnt, rcnt);
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit rst, input bit wr);
    int seen;
    bit inc;
    if (wr) wcnt++;
    rd_en            = en;
    rd_underflow_clr = clr;
    rd_rst           = rst;
    wr_ptr           = gray_of(wcnt);
    @(posedge rd_clk);
    seen = hist[SS-1];
    if (rst) begin
      rcnt    = 0;
      m_level = 0;
      m_empty = 1'b1;
      m_ae    = 1'b1;
      m_uf    = 1'b0;
      for (int i = 0; i < SS; i++) hist[i] = 0;
    end else begin
      inc     = en && !m_empty;
      m_uf    = (en && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
      rcnt    = rcnt + int'(inc);
      m_level = seen - rcnt;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= AE);
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wcnt;
    end
    #1;
    chk("empty",    32'(rd_empty),        32'(m_empty));
    chk("aempty",   32'(rd_almost_empty), 32'(m_ae));
    chk("level",    32'(rd_level),        32'(m_level));
    chk("addr",     32'(rd_addr),         32'(rcnt % DEPTH));
    chk("ptr",      32'(rd_ptr),          32'(gray_of(rcnt)));
    chk("underflow",32'(rd_underflow),    32'(m_uf));
    $display("t=%0t rst=%0b en=%0b clr=%0b wr_ptr=%b | addr=%0d ptr=%b empty=%0b ae=%0b lvl=%0d uf=%0b",
             $time, rst, en, clr, wr_ptr, rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level, rd_underflow);
  endtask

  task automatic do_reset();
    wcnt = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < SS; i++) hist[i] = 0;

    // 1: reset with a read request and a non-zero write pointer held
    wcnt = 1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // 2: three writes, no reads; empty drops SYNC_STAGES+1 edges after the first
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvl3", 32'(rd_level), 32'(3));

    // 3: drain the three entries
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ptr_end", 32'(rd_ptr), 32'(gray_of(3)));
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 4: underflow, set-beats-clear, then clear alone
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("uf_clr", 32'(rd_underflow), 32'(m_uf));

    // 5: 70 single-entry write/read pairs to cross the pointer wrap twice
    do_reset();
    prev_msb = 0;
    for (int k = 0; k < 70; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (m_empty && guard < 10) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        guard++;
      end
      chk("wrap_wait", 32'(guard < 10), 32'(1));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("lvl_range", 32'(rd_level <= 1), 32'(1));
      if (int'(rd_ptr[AL]) != prev_msb) msb_toggles++;
      prev_msb = int'(rd_ptr[AL]);
    end
    chk("msb_toggles", 32'(msb_toggles), 32'(2));

    // 6: fill to 32, drain past the almost-empty threshold, reset mid-drain
    do_reset();
    repeat (DEPTH) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (SS + 1) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_lvl", 32'(rd_level), 32'(DEPTH));
    chk("full_ae",  32'(rd_almost_empty), 32'(0));
    repeat (DEPTH - AE) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ae_at4", 32'(rd_almost_empty), 32'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit en, clr, wr, rst;
      en  = ($urandom % 2) == 0;
      clr = ($urandom % 8) == 0;
      wr  = (($urandom % 2) == 0) && (wcnt - rcnt < DEPTH);
      rst = ($urandom % 100) == 0;
      if (rst) wcnt = 0;
      step(en, clr, rst, rst ? 1'b0 : wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
